// File: rtl/i2c_slave_mb.sv
// I2C slave with a byte-stream interface: write bytes arrive on rx_data/rx_valid,
// read bytes are requested through tx_ready/tx_data. SDA is open-drain only.
module i2c_slave_mb #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h70,
  parameter int         MAX_BYTES   = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_nack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       start,
  output logic       stop,
  output logic       rw,
  output logic [7:0] byte_cnt,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BYTES);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic scl_prev_r, sda_prev_r;
  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_cond_s, stop_cond_s;
  logic [7:0] shift_in_s;

  state_t     state_r, state_nxt_s;
  logic [2:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [6:0] shift_r, shift_nxt_s;
  logic       sda_oe_r, sda_oe_nxt_s;
  logic       rw_r, rw_nxt_s;
  logic [7:0] byte_cnt_r, byte_cnt_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic [7:0] rx_data_r, rx_data_nxt_s;
  logic       rx_valid_r, rx_valid_nxt_s;
  logic       tx_ready_r, tx_ready_nxt_s;
  logic       tx_done_r, tx_done_nxt_s;
  logic       tx_nack_r, tx_nack_nxt_s;
  logic       start_r, start_nxt_s;
  logic       stop_r, stop_nxt_s;

  // Bus synchronisers idle high so reset never fakes a START or STOP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  assign scl_s        = scl_sync_r[SYNC_STAGES-1];
  assign sda_s        = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s   = scl_s & ~scl_prev_r;
  assign scl_fall_s   = ~scl_s & scl_prev_r;
  assign start_cond_s = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_cond_s  = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
  assign shift_in_s   = {shift_r, sda_s};

  always_comb begin
    state_nxt_s    = state_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    shift_nxt_s    = shift_r;
    sda_oe_nxt_s   = sda_oe_r;
    rw_nxt_s       = rw_r;
    byte_cnt_nxt_s = byte_cnt_r;
    busy_nxt_s     = busy_r;
    rx_data_nxt_s  = rx_data_r;
    tx_nack_nxt_s  = tx_nack_r;
    rx_valid_nxt_s = 1'b0;
    tx_ready_nxt_s = 1'b0;
    tx_done_nxt_s  = 1'b0;
    start_nxt_s    = 1'b0;
    stop_nxt_s     = 1'b0;

    if (stop_cond_s) begin
      state_nxt_s  = IDLE;
      sda_oe_nxt_s = 1'b0;
      stop_nxt_s   = busy_r;
      busy_nxt_s   = 1'b0;
    end else if (start_cond_s) begin
      state_nxt_s    = ADDR;
      bit_cnt_nxt_s  = 3'd0;
      byte_cnt_nxt_s = 8'd0;
      sda_oe_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        ADDR: begin
          if (scl_rise_s) begin
            shift_nxt_s = shift_in_s[6:0];
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_nxt_s = 3'd0;
              if (shift_in_s[7:1] == SLAVE_ADDR) begin
                rw_nxt_s    = shift_in_s[0];
                start_nxt_s = 1'b1;
                busy_nxt_s  = 1'b1;
                state_nxt_s = ADDR_ACK;
              end else begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = WAIT_STOP;
              end
            end else begin
              bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            shift_nxt_s = shift_r;
          end
        end
        // sda_oe doubles as the phase flag: first fall pulls low, second releases
        ADDR_ACK, WR_ACK: begin
          if (scl_fall_s) begin
            if (!sda_oe_r) begin
              sda_oe_nxt_s = 1'b1;
            end else begin
              sda_oe_nxt_s = 1'b0;
              if (state_r == ADDR_ACK && rw_r) begin
                state_nxt_s    = RD_DATA;
                tx_ready_nxt_s = 1'b1;
              end else begin
                state_nxt_s = WR_DATA;
              end
            end
          end else begin
            sda_oe_nxt_s = sda_oe_r;
          end
        end
        WR_DATA: begin
          if (scl_rise_s) begin
            shift_nxt_s = shift_in_s[6:0];
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_nxt_s = 3'd0;
              if (byte_cnt_r < MAX_B) begin
                rx_data_nxt_s  = shift_in_s;
                rx_valid_nxt_s = 1'b1;
                byte_cnt_nxt_s = sat_inc(byte_cnt_r);
                state_nxt_s    = WR_ACK;
              end else begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = WAIT_STOP;
              end
            end else begin
              bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            shift_nxt_s = shift_r;
          end
        end
        // tx_data is captured the cycle tx_ready is high; MSB goes out immediately
        RD_DATA: begin
          if (tx_ready_r) begin
            shift_nxt_s   = tx_data[6:0];
            sda_oe_nxt_s  = ~tx_data[7];
            bit_cnt_nxt_s = 3'd0;
          end else if (scl_fall_s) begin
            if (bit_cnt_r == 3'd7) begin
              sda_oe_nxt_s  = 1'b0;
              bit_cnt_nxt_s = 3'd0;
              state_nxt_s   = RD_ACK;
            end else begin
              sda_oe_nxt_s  = ~shift_r[6];
              shift_nxt_s   = {shift_r[5:0], 1'b0};
              bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            sda_oe_nxt_s = sda_oe_r;
          end
        end
        // bit_cnt 0: awaiting master ACK bit, 1: ACK seen, reload on next fall
        RD_ACK: begin
          if (scl_rise_s && bit_cnt_r == 3'd0) begin
            tx_done_nxt_s  = 1'b1;
            tx_nack_nxt_s  = sda_s;
            byte_cnt_nxt_s = sat_inc(byte_cnt_r);
            if (sda_s) begin
              busy_nxt_s  = 1'b0;
              state_nxt_s = WAIT_STOP;
            end else begin
              bit_cnt_nxt_s = 3'd1;
            end
          end else if (scl_fall_s && bit_cnt_r == 3'd1) begin
            tx_ready_nxt_s = 1'b1;
            bit_cnt_nxt_s  = 3'd0;
            state_nxt_s    = RD_DATA;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r;
          end
        end
        IDLE, WAIT_STOP: begin
          sda_oe_nxt_s = 1'b0;
        end
        default: begin
          state_nxt_s  = IDLE;
          sda_oe_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Protocol state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 7'd0;
      sda_oe_r   <= 1'b0;
      rw_r       <= 1'b0;
      byte_cnt_r <= 8'd0;
      busy_r     <= 1'b0;
      rx_data_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      tx_ready_r <= 1'b0;
      tx_done_r  <= 1'b0;
      tx_nack_r  <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      sda_oe_r   <= sda_oe_nxt_s;
      rw_r       <= rw_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
      busy_r     <= busy_nxt_s;
      rx_data_r  <= rx_data_nxt_s;
      rx_valid_r <= rx_valid_nxt_s;
      tx_ready_r <= tx_ready_nxt_s;
      tx_done_r  <= tx_done_nxt_s;
      tx_nack_r  <= tx_nack_nxt_s;
      start_r    <= start_nxt_s;
      stop_r     <= stop_nxt_s;
    end
  end

  assign sda      = sda_oe_r ? 1'b0 : 1'bz;
  assign tx_ready = tx_ready_r;
  assign tx_done  = tx_done_r;
  assign tx_nack  = tx_nack_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign start    = start_r;
  assign stop     = stop_r;
  assign rw       = rw_r;
  assign byte_cnt = byte_cnt_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_slave_mb.sv
// Directed bench for i2c_slave_mb: bit-banged master on a pulled-up SDA line,
// pulse monitors, and hand-computed expectations.
`timescale 1ns/1ps
module tb_i2c_slave_mb;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_low;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, tx_nack, rx_valid, start, stop, rw, busy;
  logic [7:0] rx_data, byte_cnt;
  wire        sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  logic [7:0] tx_tab [0:3];
  int         tx_idx = 0;
  logic       tx_ready_seen = 1'b0;
  assign tx_data = tx_tab[tx_idx[1:0]];

  int checks = 0;
  int failures = 0;
  int n_start = 0, n_stop = 0, n_txr = 0;
  logic slave_drove = 1'b0;
  logic [7:0] rx_q[$];
  logic       nack_q[$];
  logic       rw_q[$];

  i2c_slave_mb dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .tx_data(tx_data), .tx_ready(tx_ready), .tx_done(tx_done), .tx_nack(tx_nack),
    .rx_data(rx_data), .rx_valid(rx_valid), .start(start), .stop(stop),
    .rw(rw), .byte_cnt(byte_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor; tx_data advances one cycle after the DUT has captured it
  always @(negedge clk) begin
    if (tx_ready_seen) tx_idx++;
    tx_ready_seen = tx_ready;
    if (tx_ready) n_txr++;
    if (start) begin n_start++; rw_q.push_back(rw); end
    if (stop) n_stop++;
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_done) nack_q.push_back(tx_nack);
    if (!m_low && sda === 1'b0) slave_drove = 1'b1;
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    wait_q(1); m_low = ~b;
    wait_q(1); scl = 1'b1;
    wait_q(1); s = sda;
    wait_q(1); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(nack, s);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_q(1);
    scl = 1'b1;   wait_q(1);
    m_low = 1'b1; wait_q(1);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q(1);
    scl = 1'b1;   wait_q(1);
    m_low = 1'b0; wait_q(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a0, a1, a2, a3, a4, a5;
    logic [7:0] d0, d1;
    int n0, s0, p0, r0, k0;

    tx_tab[0] = 8'hA5; tx_tab[1] = 8'h3C; tx_tab[2] = 8'hC3; tx_tab[3] = 8'h00;
    reset = 1'b1; scl = 1'b1; m_low = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_byte_cnt", byte_cnt, 8'd0);
    check_eq("rst_rx_data", rx_data, 8'd0);
    check_eq("rst_pulses", {start, stop, rx_valid, tx_ready, tx_done, tx_nack, rw}, 7'd0);
    check_eq("rst_sda", sda, 1'b1);
    reset = 1'b0;
    wait_q(2);

    // Two-byte write, then STOP
    i2c_start();
    send_byte(8'hE0, a0);
    check_eq("w_busy", busy, 1'b1);
    send_byte(8'h12, a1);
    send_byte(8'h34, a2);
    check_eq("w_acks", {a0, a1, a2}, 3'b111);
    check_eq("w_byte_cnt", byte_cnt, 8'd2);
    i2c_stop();
    check_eq("w_rx_count", rx_q.size(), 2);
    check_eq("w_rx0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h12);
    check_eq("w_rx1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h34);
    check_eq("w_start", n_start, 1);
    check_eq("w_stop", n_stop, 1);
    check_eq("w_busy_after", busy, 1'b0);
    check_eq("w_rw", rw, 1'b0);

    // Foreign address 0x55: slave stays off the bus
    wait_q(2);
    slave_drove = 1'b0; n0 = rx_q.size();
    i2c_start();
    send_byte(8'hAA, a0);
    send_byte(8'h12, a1);
    check_eq("mis_acks", {a0, a1}, 2'b00);
    check_eq("mis_busy", busy, 1'b0);
    check_eq("mis_byte_cnt", byte_cnt, 8'd0);
    i2c_stop();
    check_eq("mis_drove", slave_drove, 1'b0);
    check_eq("mis_start", n_start, 1);
    check_eq("mis_stop", n_stop, 1);
    check_eq("mis_rx", rx_q.size(), n0);

    // Five-byte write against a four-byte limit
    wait_q(2);
    n0 = rx_q.size(); s0 = n_stop;
    i2c_start();
    send_byte(8'hE0, a0);
    send_byte(8'h11, a1);
    send_byte(8'h22, a2);
    send_byte(8'h33, a3);
    send_byte(8'h44, a4);
    send_byte(8'h55, a5);
    check_eq("max_acks", {a0, a1, a2, a3, a4, a5}, 6'b111110);
    check_eq("max_busy", busy, 1'b0);
    check_eq("max_byte_cnt", byte_cnt, 8'd4);
    check_eq("max_rx_data", rx_data, 8'h44);
    i2c_stop();
    check_eq("max_rx_count", rx_q.size() - n0, 4);
    check_eq("max_stop", n_stop - s0, 0);

    // Read two bytes, master ACKs the first and NACKs the second
    wait_q(2);
    k0 = nack_q.size(); r0 = n_txr; s0 = n_stop;
    i2c_start();
    send_byte(8'hE1, a0);
    check_eq("r_addr_ack", a0, 1'b1);
    check_eq("r_rw", rw, 1'b1);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    check_eq("r_byte0", d0, 8'hA5);
    check_eq("r_byte1", d1, 8'h3C);
    check_eq("r_done_count", nack_q.size() - k0, 2);
    check_eq("r_nack0", (nack_q.size() > k0) ? nack_q[k0] : 1'bx, 1'b0);
    check_eq("r_nack1", (nack_q.size() > k0 + 1) ? nack_q[k0+1] : 1'bx, 1'b1);
    check_eq("r_tx_ready", n_txr - r0, 2);
    check_eq("r_byte_cnt", byte_cnt, 8'd2);
    check_eq("r_busy", busy, 1'b0);
    i2c_stop();
    check_eq("r_stop", n_stop - s0, 0);

    // Write one byte, repeated START, then read
    wait_q(2);
    p0 = n_start; n0 = rw_q.size();
    i2c_start();
    send_byte(8'hE0, a0);
    send_byte(8'h01, a1);
    check_eq("rs_byte_cnt_w", byte_cnt, 8'd1);
    i2c_start();
    send_byte(8'hE1, a2);
    check_eq("rs_acks", {a0, a1, a2}, 3'b111);
    check_eq("rs_byte_cnt_r", byte_cnt, 8'd0);
    check_eq("rs_start", n_start - p0, 2);
    check_eq("rs_rw0", (rw_q.size() > n0) ? rw_q[n0] : 1'bx, 1'b0);
    check_eq("rs_rw1", (rw_q.size() > n0 + 1) ? rw_q[n0+1] : 1'bx, 1'b1);
    recv_byte(1'b1, d0);
    check_eq("rs_byte", d0, 8'hC3);
    i2c_stop();

    // Reset while the slave holds the address ACK
    wait_q(2);
    i2c_start();
    for (int i = 7; i >= 0; i--) bus_bit(a0 & 1'b0 | ((8'hE0 >> i) & 8'h01) != 8'h00, a1);
    m_low = 1'b0;
    wait_q(1);
    check_eq("ra_ack_drive", sda, 1'b0);
    check_eq("ra_busy_pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("ra_sda_release", sda, 1'b1);
    check_eq("ra_outputs", {busy, rw, tx_nack, start, stop, rx_valid, tx_ready, tx_done}, 8'd0);
    check_eq("ra_rx_data", rx_data, 8'd0);
    check_eq("ra_byte_cnt", byte_cnt, 8'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    scl = 1'b1;
    wait_q(2);

    // Slave is usable again after reset
    i2c_start();
    send_byte(8'hE0, a0);
    send_byte(8'h5A, a1);
    check_eq("post_acks", {a0, a1}, 2'b11);
    check_eq("post_rx_data", rx_data, 8'h5A);
    i2c_stop();
    wait_q(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_mb.md
I2C_SLAVE_MB -- requirements
Module: i2c_slave_mb

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h70, 7-bit address the block responds to.
REQ-002 SHALL have parameter MAX_BYTES, default 4, data bytes ACKed per write transfer (1..255).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for scl/sda (>=2).
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port scl  input  1  I2C clock from master.
REQ-007 SHALL have port sda  inout  1  I2C data, open-drain: driven 0 or high-Z only, never driven 1.
REQ-008 SHALL have port tx_data  input  8  byte to send on read, sampled in the tx_ready cycle.
REQ-009 SHALL have port tx_ready  output  1  1-clk pulse: block is loading tx_data now.
REQ-010 SHALL have port tx_done  output  1  1-clk pulse: byte sent and master ACK/NACK sampled.
REQ-011 SHALL have port tx_nack  output  1  master NACK bit of last byte, valid with tx_done.
REQ-012 SHALL have port rx_data  output  8  last received data byte, held until next one.
REQ-013 SHALL have port rx_valid  output  1  1-clk pulse: rx_data updated with an ACKed byte.
REQ-014 SHALL have port start  output  1  1-clk pulse on address match (START or repeated START).
REQ-015 SHALL have port stop  output  1  1-clk pulse on STOP while addressed.
REQ-016 SHALL have port rw  output  1  R/W bit of current transfer (1 = master reads).
REQ-017 SHALL have port byte_cnt  output  8  data bytes completed in current transfer.
REQ-018 SHALL have port busy  output  1  high from address match until STOP, NACK or mismatch.

Function
REQ-019 SHALL pass scl and sda through SYNC_STAGES flops; all edge/level logic uses synchronised values.
REQ-020 SHALL detect START as synced sda falling while synced scl high, STOP as sda rising while scl high, in any state.
REQ-021 SHALL on any START clear bit counter and byte_cnt and enter ADDR, including mid-byte (repeated START).
REQ-022 SHALL on any STOP release sda and enter IDLE; stop pulses only if busy was high.
REQ-023 SHALL sample sda MSB-first on scl rising edges; SHALL change sda drive only on scl falling edges.
REQ-024 SHALL use states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-025 ADDR: after 8th rising edge, if addr[7:1]==SLAVE_ADDR latch rw, pulse start, assert busy, go ADDR_ACK; else go WAIT_STOP, sda never driven.
REQ-026 ADDR_ACK: drive sda 0 from next scl falling edge to the following falling edge; then go WR_DATA (rw=0) or RD_DATA (rw=1).
REQ-027 WR_DATA: after 8th bit, if byte_cnt<MAX_BYTES, update rx_data, pulse rx_valid, increment byte_cnt, go WR_ACK (ACK as REQ-026), return to WR_DATA.
REQ-028 WR_DATA when byte_cnt==MAX_BYTES: SHALL not ACK, not pulse rx_valid, clear busy, go WAIT_STOP.
REQ-029 RD_DATA: pulse tx_ready on the scl falling edge that ends the address/ACK phase, load tx_data into shift register, drive MSB (0 -> pull low, 1 -> release) in same edge.
REQ-030 RD_DATA: shift on each of next 7 falling edges; release sda on 8th falling edge; go RD_ACK.
REQ-031 RD_ACK: sample sda on rising edge; pulse tx_done, set tx_nack=sda, increment byte_cnt; ACK -> RD_DATA next falling edge (REQ-029 reload); NACK -> clear busy, WAIT_STOP.
REQ-032 WAIT_STOP: sda released; ignore bus until START or STOP.
REQ-033 byte_cnt SHALL saturate at 255.
REQ-034 START and STOP in same clk cannot occur; if STOP and scl edge coincide, STOP wins.

Reset
REQ-035 SHALL on reset: state IDLE, sda high-Z, all pulses 0, rx_data 0, rw 0, byte_cnt 0, busy 0, tx_nack 0, synchronisers 1.
REQ-036 SHALL on reset mid-transfer release sda within the same clock (asynchronous).

Verification
REQ-037 Write 0xE0,0x12,0x34, STOP -> ACK each, rx_valid twice with 0x12 then 0x34, byte_cnt=2, stop pulse.
REQ-038 Address 0x55 write -> no ACK, no start, sda never driven, busy 0 until next START.
REQ-039 Write 5 bytes with MAX_BYTES=4 -> bytes 1-4 ACKed, 5th NACKed, rx_data=byte 4.
REQ-040 Read 0xE1, tx_data 0xA5 then 0x3C, master ACK then NACK -> bus shows A5,3C; tx_done twice, tx_nack 0 then 1.
REQ-041 Write 0xE0,0x01, repeated START, 0xE1 read -> start pulses twice, rw 0 then 1, byte_cnt reset to 0.
REQ-042 Assert reset while slave drives ACK -> sda high-Z immediately, all outputs at reset values.
